datapath_ctrl: RTL and testbench
================================

// Module: datapath_ctrl
// PURPOSE
//  Moore FSM that sequences the 16-bit datapath (8x16 regfile, A/B/C/status regs, shifter, ALU).
//  Latches one Simple RISC instruction on a start/wait handshake, decodes it and drives
//  readnum/writenum/write, the load enables, the mux selects, the shift and ALU op.
//  Sits between the instruction source (switches or fetch unit) and the datapath.
// PARAMETERS
//  DW  16  datapath / instruction width
//  RW  3   register index width (2**RW = 8 registers)
// PORTS
//  clk       in   1   rising-edge clock; the only clock
//  reset_n   in   1   asynchronous, active-low reset
//  s         in   1   start request; sampled only while w=1
//  instr     in   DW  instruction; captured into internal IR when s is accepted
//  w         out  1   1 = idle in WAIT, ready for s
//  readnum   out  RW  regfile read index
//  writenum  out  RW  regfile write index
//  write     out  1   regfile write enable
//  loada     out  1   load A register
//  loadb     out  1   load B register
//  loadc     out  1   load C register
//  loads     out  1   load status flags
//  asel      out  1   1 = ALU A input forced to 0
//  bsel      out  1   1 = ALU B input from sximm5 (always 0 in this block)
//  vsel      out  2   write-back source: 00 = C, 10 = sximm8 (01/11 never driven)
//  shift     out  2   shifter op = IR[4:3]
//  ALUop     out  2   00 ADD, 01 SUB, 10 AND, 11 NOT B
//  sximm8    out  DW  sign-extended IR[7:0]
//  sximm5    out  DW  sign-extended IR[4:0]
//  illegal   out  1   1-cycle pulse on an undefined opcode
// BEHAVIOUR
//  IR fields: opcode[15:13] op[12:11] Rn[10:8] Rd[7:5] sh[4:3] Rm[2:0] imm8[7:0]
//  - Reset (async, reset_n=0): state=WAIT, IR=0. w=1; every other control output 0.
//    Reset mid-instruction aborts it; no write issued after the reset assertion.
//  - WAIT: w=1. On the edge with s=1: IR<=instr, go to DECODE. s=0: stay. While w=0, s and instr are ignored.
//  - DECODE (all controls 0):
//      110/10 MOV Rn,#imm8 -> WRITE_IMM
//      110/00 MOV Rd,Rm{,sh} -> GET_B
//      101/00 ADD | 101/01 CMP | 101/10 AND -> GET_A
//      101/11 MVN -> GET_B
//      anything else -> WAIT with illegal=1 for this cycle
//  - GET_A: readnum=Rn, loada=1 -> GET_B
//  - GET_B: readnum=Rm, loadb=1 -> EXEC
//  - EXEC: shift=sh, bsel=0; asel=1 for MOV (ALUop=00), asel=0 otherwise; ALUop=op for 101.
//    CMP: loads=1, loadc=0 -> WAIT. Others: loadc=1 -> WRITE_REG
//  - WRITE_REG: writenum=Rd, vsel=00, write=1 -> WAIT
//  - WRITE_IMM: writenum=Rn, vsel=10, write=1 -> WAIT
//  - Outputs are decoded from state+IR only (Moore); each is 0 in any state not listed above.
//  - Latency: s edge to w=1 = MOV imm 3 clocks, MOV reg/MVN 5, CMP 5, ADD/AND 6.
//  - Back-to-back: s held high in WAIT starts the next instruction on the first edge w=1 is seen.
//  - sximm8/sximm5 are combinational from IR: sign bit replicated to DW bits.
//  - Illegal states in the state encoding return to WAIT on the next edge.
// TESTING
//  1. Reset: reset_n=0 mid-GET_B -> w=1, write=0, loadb=0 immediately, before any clk edge.
//  2. s=1, instr=16'hD007 (MOV R0,#7) -> WRITE_IMM: write=1, writenum=0, vsel=10, sximm8=16'h0007; w=1 3 clocks after s.
//  3. instr=16'hA148 (ADD R2,R1,R0,LSL#1) -> readnum 1 then 0, shift=01, ALUop=00, loadc, then write to R2; w=1 after 6 clocks.
//  4. instr=16'hA901 (CMP R1,R1) -> loads=1 in EXEC; write never asserted; w=1 after 5 clocks.
//  5. instr=16'hE000 (opcode 111) -> illegal pulses 1 cycle in DECODE, back to WAIT, no load/write.
//  6. s pulsed while busy with a different instr -> ignored; IR and the write target stay unchanged.
//  7. instr=16'hD080 (MOV R0,#-128) -> sximm8=16'hFF80.
//  Bench pairs this block with the regfile and checks read-back values after each instruction.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Moore sequencer for the Simple RISC 16-bit datapath: latches one instruction on the
// start/wait handshake, then steps the regfile, A/B/C/status loads and ALU controls.
module datapath_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          s,
    input  logic [DW-1:0] instr,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] sximm8,
    output logic [DW-1:0] sximm5,
    output logic          illegal
);

    typedef enum logic [2:0] {
        StWait     = 3'd0,
        StDecode   = 3'd1,
        StGetA     = 3'd2,
        StGetB     = 3'd3,
        StExec     = 3'd4,
        StWriteReg = 3'd5,
        StWriteImm = 3'd6
    } state_e;

    localparam logic [2:0] OpcMov = 3'b110;
    localparam logic [2:0] OpcAlu = 3'b101;

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;

    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [1:0]    sh;
    logic [RW-1:0] rn, rd, rm;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign sh     = ir_q[4:3];
    assign rn     = ir_q[8 +: RW];
    assign rd     = ir_q[5 +: RW];
    assign rm     = ir_q[0 +: RW];

    assign sximm8 = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
    assign sximm5 = {{(DW-5){ir_q[4]}}, ir_q[4:0]};

    // IR only loads when the handshake is accepted; s/instr are don't-care while busy.
    assign ir_d = (state_q == StWait && s) ? instr : ir_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StWait;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        shift    = 2'b00;
        ALUop    = 2'b00;
        illegal  = 1'b0;
        case (state_q)
            StWait: begin
                w = 1'b1;
                if (s) state_d = StDecode;
            end
            StDecode: begin
                if (opcode == OpcMov && op == 2'b10) begin
                    state_d = StWriteImm;
                end else if (opcode == OpcMov && op == 2'b00) begin
                    state_d = StGetB;
                end else if (opcode == OpcAlu) begin
                    // MVN only needs the B operand.
                    state_d = (op == 2'b11) ? StGetB : StGetA;
                end else begin
                    state_d = StWait;
                    illegal = 1'b1;
                end
            end
            StGetA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = StGetB;
            end
            StGetB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = StExec;
            end
            StExec: begin
                shift = sh;
                if (opcode == OpcMov) asel = 1'b1;
                else                  ALUop = op;
                if (opcode == OpcAlu && op == 2'b01) begin
                    loads   = 1'b1;
                    state_d = StWait;
                end else begin
                    loadc   = 1'b1;
                    state_d = StWriteReg;
                end
            end
            StWriteReg: begin
                writenum = rd;
                write    = 1'b1;
                state_d  = StWait;
            end
            StWriteImm: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
                state_d  = StWait;
            end
            default: state_d = StWait;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: per-cycle control vectors are queued at issue time and checked
// by a monitor; a small behavioural datapath lets register read-back be checked too.
module tb_datapath_ctrl;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] alu;
        logic       illegal;
    } ctl_t;

    typedef struct {
        string tag;
        ctl_t  c;
    } item_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s;
    logic [15:0] instr;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, shift, ALUop;
    logic [15:0] sximm8, sximm5;

    int    checks = 0;
    int    passes = 0;
    item_t sb[$];
    ctl_t  act;

    datapath_ctrl #(.DW(16), .RW(3)) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .instr(instr), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
                  vsel, shift, ALUop, illegal};

    // Behavioural datapath driven by the controller.
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] ra, rb, rc, sh_out, ain, bin, alu_out;
    logic        z;
    int          writes_n = 0;

    always_comb begin
        case (shift)
            2'b01:   sh_out = {rb[14:0], 1'b0};
            2'b10:   sh_out = {1'b0, rb[15:1]};
            2'b11:   sh_out = {rb[15], rb[15:1]};
            default: sh_out = rb;
        endcase
        ain = asel ? 16'h0000 : ra;
        bin = bsel ? sximm5 : sh_out;
        case (ALUop)
            2'b01:   alu_out = ain - bin;
            2'b10:   alu_out = ain & bin;
            2'b11:   alu_out = ~bin;
            default: alu_out = ain + bin;
        endcase
    end

    always @(posedge clk) begin
        if (write) begin
            rf[writenum] <= (vsel == 2'b10) ? sximm8 : rc;
            writes_n     <= writes_n + 1;
        end
        if (loada) ra <= rf[readnum];
        if (loadb) rb <= rf[readnum];
        if (loadc) rc <= alu_out;
        if (loads) z  <= (alu_out == 16'h0000);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Monitor: every sampled cycle with something queued is compared against the head.
    always @(negedge clk) begin
        if (reset_n && sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            chk(it.tag, 32'(act), 32'(it.c));
        end
    end

    function automatic ctl_t c_wait();
        ctl_t c = '0;
        c.w = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_dec(input logic ill);
        ctl_t c = '0;
        c.illegal = ill;
        return c;
    endfunction
    function automatic ctl_t c_geta(input logic [2:0] rn);
        ctl_t c = '0;
        c.readnum = rn;
        c.loada   = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_getb(input logic [2:0] rm);
        ctl_t c = '0;
        c.readnum = rm;
        c.loadb   = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_exec(input logic as, input logic [1:0] sh, input logic [1:0] op,
                                    input logic cmp);
        ctl_t c = '0;
        c.asel  = as;
        c.shift = sh;
        c.alu   = op;
        c.loads = cmp;
        c.loadc = ~cmp;
        return c;
    endfunction
    function automatic ctl_t c_wreg(input logic [2:0] rd);
        ctl_t c = '0;
        c.writenum = rd;
        c.write    = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_wimm(input logic [2:0] rn);
        ctl_t c = '0;
        c.writenum = rn;
        c.vsel     = 2'b10;
        c.write    = 1'b1;
        return c;
    endfunction

    task automatic push(input string tag, input ctl_t c);
        item_t it;
        it.tag = tag;
        it.c   = c;
        sb.push_back(it);
    endtask

    task automatic issue(input logic [15:0] ins);
        @(negedge clk);
        s     = 1'b1;
        instr = ins;
        @(posedge clk);
        #1 s = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        reset_n = 1'b0;
        s       = 1'b0;
        instr   = 16'h0000;
        #12;
        chk("reset ctl", 32'(act), 32'(c_wait()));
        chk("reset sximm8", 32'(sximm8), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // MOV R0,#7 and MOV R1,#3
        issue(16'hD007);
        push("movi0 dec", c_dec(1'b0));
        push("movi0 wimm", c_wimm(3'd0));
        push("movi0 wait", c_wait());
        chk("movi0 sximm8", 32'(sximm8), 32'h0007);
        chk("movi0 sximm5", 32'(sximm5), 32'h0007);
        drain();
        issue(16'hD103);
        push("movi1 dec", c_dec(1'b0));
        push("movi1 wimm", c_wimm(3'd1));
        push("movi1 wait", c_wait());
        drain();
        chk("R0 after movi", 32'(rf[0]), 32'h0007);

        // ADD aborted by async reset while in GET_B
        @(negedge clk);
        s     = 1'b1;
        instr = 16'hA148;
        @(posedge clk);
        #1 s = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 chk("pre-reset loadb", 32'(loadb), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset w", 32'(w), 32'd1);
        chk("async reset write", 32'(write), 32'd0);
        chk("async reset loadb", 32'(loadb), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("R2 after abort", 32'(rf[2]), 32'h0000);

        // ADD R2,R1,R0,LSL#1 -> 3 + 14
        issue(16'hA148);
        push("add dec", c_dec(1'b0));
        push("add geta", c_geta(3'd1));
        push("add getb", c_getb(3'd0));
        push("add exec", c_exec(1'b0, 2'b01, 2'b00, 1'b0));
        push("add wreg", c_wreg(3'd2));
        push("add wait", c_wait());
        chk("add sximm5", 32'(sximm5), 32'h0008);
        drain();
        chk("R2 after add", 32'(rf[2]), 32'h0011);

        // CMP R1,R1: flags only, no write
        wr0 = writes_n;
        issue(16'hA901);
        push("cmp dec", c_dec(1'b0));
        push("cmp geta", c_geta(3'd1));
        push("cmp getb", c_getb(3'd1));
        push("cmp exec", c_exec(1'b0, 2'b00, 2'b01, 1'b1));
        push("cmp wait", c_wait());
        drain();
        chk("cmp Z", 32'(z), 32'd1);
        chk("cmp no write", 32'(writes_n), 32'(wr0));

        // Undefined opcode 111
        issue(16'hE000);
        push("ill dec", c_dec(1'b1));
        push("ill wait", c_wait());
        drain();
        chk("ill no write", 32'(writes_n), 32'(wr0));

        // MOV R3,R2,LSR#1 -> 8
        issue(16'hC072);
        push("movr dec", c_dec(1'b0));
        push("movr getb", c_getb(3'd2));
        push("movr exec", c_exec(1'b1, 2'b10, 2'b00, 1'b0));
        push("movr wreg", c_wreg(3'd3));
        push("movr wait", c_wait());
        chk("movr sximm5", 32'(sximm5), 32'h0000FFF2);
        drain();
        chk("R3 after movr", 32'(rf[3]), 32'h0008);

        // MVN R4,R0 -> ~7
        issue(16'hB880);
        push("mvn dec", c_dec(1'b0));
        push("mvn getb", c_getb(3'd0));
        push("mvn exec", c_exec(1'b0, 2'b00, 2'b11, 1'b0));
        push("mvn wreg", c_wreg(3'd4));
        push("mvn wait", c_wait());
        drain();
        chk("R4 after mvn", 32'(rf[4]), 32'h0000FFF8);

        // AND R5,R4,R1 -> FFF8 & 3
        issue(16'hB4A1);
        push("and dec", c_dec(1'b0));
        push("and geta", c_geta(3'd4));
        push("and getb", c_getb(3'd1));
        push("and exec", c_exec(1'b0, 2'b00, 2'b10, 1'b0));
        push("and wreg", c_wreg(3'd5));
        push("and wait", c_wait());
        drain();
        chk("R5 after and", 32'(rf[5]), 32'h0000);

        // MOV R6,#5 with a stray s/instr pulse while busy
        issue(16'hD605);
        push("busy dec", c_dec(1'b0));
        push("busy wimm", c_wimm(3'd6));
        push("busy wait", c_wait());
        @(negedge clk);
        s     = 1'b1;
        instr = 16'hD7FF;
        @(posedge clk);
        #1 s = 1'b0;
        instr = 16'hD605;
        drain();
        chk("R6 after busy", 32'(rf[6]), 32'h0005);
        chk("R7 untouched", 32'(rf[7]), 32'h0000);

        // Back-to-back: s held through the WAIT cycle restarts immediately
        wr0 = writes_n;
        @(negedge clk);
        s     = 1'b1;
        instr = 16'hD109;
        @(posedge clk);
        push("b2b dec0", c_dec(1'b0));
        push("b2b wimm0", c_wimm(3'd1));
        push("b2b wait0", c_wait());
        push("b2b dec1", c_dec(1'b0));
        push("b2b wimm1", c_wimm(3'd1));
        push("b2b wait1", c_wait());
        repeat (3) @(posedge clk);
        #1 s = 1'b0;
        drain();
        chk("b2b writes", 32'(writes_n - wr0), 32'd2);
        chk("R1 after b2b", 32'(rf[1]), 32'h0009);

        // MOV R0,#-128
        issue(16'hD080);
        push("neg dec", c_dec(1'b0));
        push("neg wimm", c_wimm(3'd0));
        push("neg wait", c_wait());
        chk("neg sximm8", 32'(sximm8), 32'h0000FF80);
        chk("neg sximm5", 32'(sximm5), 32'h0000);
        drain();
        chk("R0 after neg", 32'(rf[0]), 32'h0000FF80);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
